// File: rtl/rs_pkg.sv
// Shared reservation-station definitions: payload field offsets,
// widths and the RS type codes used by dispatch.
package rs_pkg;

    localparam int DATA_W  = 76;
    localparam int TAG_W   = 5;
    localparam int NUM_CDB = 2;

    localparam int SRC1_TAG_LSB = 71;
    localparam int SRC1_RDY     = 70;
    localparam int SRC2_TAG_LSB = 65;
    localparam int SRC2_RDY     = 64;

    typedef enum logic [1:0] {
        RS_BUBBLE  = 2'b00,
        RS_COMPLEX = 2'b01,
        RS_FP      = 2'b10,
        RS_SIMPLE  = 2'b11
    } rs_type_e;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: payload, valid bit and
// CDB tag comparators for capture bypass and wakeup.
module rs_entry
    import rs_pkg::*;
#(
    parameter int DATA_W  = 76,
    parameter int TAG_W   = 5,
    parameter int NUM_CDB = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     free,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    output logic                     valid,
    output logic [DATA_W-1:0]        data,
    output logic                     ready
);

    logic cap1, cap2, wk1, wk2;

    always_comb begin
        cap1 = 1'b0;
        cap2 = 1'b0;
        wk1  = 1'b0;
        wk2  = 1'b0;
        for (int p = 0; p < NUM_CDB; p++) begin
            if (cdb_valid[p]) begin
                if (cdb_tag[p*TAG_W +: TAG_W] == wr_data[SRC1_TAG_LSB +: TAG_W])
                    cap1 = 1'b1;
                if (cdb_tag[p*TAG_W +: TAG_W] == wr_data[SRC2_TAG_LSB +: TAG_W])
                    cap2 = 1'b1;
                if (cdb_tag[p*TAG_W +: TAG_W] == data[SRC1_TAG_LSB +: TAG_W])
                    wk1 = 1'b1;
                if (cdb_tag[p*TAG_W +: TAG_W] == data[SRC2_TAG_LSB +: TAG_W])
                    wk2 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr) begin
            valid          <= 1'b1;
            data           <= wr_data;
            data[SRC1_RDY] <= wr_data[SRC1_RDY] | cap1;
            data[SRC2_RDY] <= wr_data[SRC2_RDY] | cap2;
        end else if (valid) begin
            if (free)
                valid <= 1'b0;
            if (wk1)
                data[SRC1_RDY] <= 1'b1;
            if (wk2)
                data[SRC2_RDY] <= 1'b1;
        end
    end

    assign ready = valid & data[SRC1_RDY] & data[SRC2_RDY];

endmodule

// File: rtl/rs_pair.sv
// Two-entry reservation station: oldest-ready select, stall lock
// on the issue handshake, and flush of all entries.
module rs_pair
    import rs_pkg::*;
#(
    parameter int DATA_W  = 76,
    parameter int TAG_W   = 5,
    parameter int NUM_CDB = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        in_0_data,
    input  logic                     in_0_valid,
    input  logic [DATA_W-1:0]        in_1_data,
    input  logic                     in_1_valid,
    output logic                     empty_0,
    output logic                     empty_1,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    output logic                     issue_valid,
    output logic [DATA_W-1:0]        issue_data,
    output logic                     issue_slot,
    input  logic                     issue_ready
);

    logic              v0, v1, r0, r1;
    logic [DATA_W-1:0] d0, d1;
    logic              old1, lock, lock_slot, sel;
    logic              wr0, wr1, acc, fr0, fr1;

    assign empty_0 = ~v0;
    assign empty_1 = ~v1;
    assign wr0     = in_0_valid & ~v0;
    assign wr1     = in_1_valid & ~v1;

    rs_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_e0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr(wr0), .wr_data(in_0_data), .free(fr0),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .valid(v0), .data(d0), .ready(r0)
    );

    rs_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_e1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr(wr1), .wr_data(in_1_data), .free(fr1),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .valid(v1), .data(d1), .ready(r1)
    );

    // A stalled offer stays pinned so the FU sees a stable payload.
    always_comb begin
        if (lock)
            sel = lock_slot;
        else if (r0 & r1)
            sel = old1;
        else
            sel = r1;
    end

    assign issue_valid = lock | r0 | r1;
    assign issue_slot  = sel;
    assign issue_data  = issue_valid ? (sel ? d1 : d0) : '0;
    assign acc         = issue_valid & issue_ready;
    assign fr0         = acc & ~sel;
    assign fr1         = acc & sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            old1      <= 1'b0;
            lock      <= 1'b0;
            lock_slot <= 1'b0;
        end else if (flush) begin
            old1 <= 1'b0;
            lock <= 1'b0;
        end else begin
            if (wr0 & wr1)
                old1 <= 1'b0;
            else if (wr0)
                old1 <= 1'b1;
            else if (wr1)
                old1 <= 1'b0;
            else if (fr0)
                old1 <= 1'b1;
            else if (fr1)
                old1 <= 1'b0;

            if (acc) begin
                lock <= 1'b0;
            end else if (issue_valid) begin
                lock      <= 1'b1;
                lock_slot <= sel;
            end
        end
    end

    // Writing an occupied slot is dropped; a flush discards it anyway.
    a_wr0_full: assert property (@(posedge clk) disable iff (!rst_n)
        flush || !(in_0_valid && v0));
    a_wr1_full: assert property (@(posedge clk) disable iff (!rst_n)
        flush || !(in_1_valid && v1));

endmodule

// File: tb/tb_rs_pair.sv
// Testbench for rs_pair: directed scenarios plus randomized traffic
// against an age-stamped behavioural model of the two slots.
module tb_rs_pair;

    localparam int DW = 76;
    localparam int TW = 5;
    localparam int NC = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [DW-1:0]     in_0_data = '0;
    logic              in_0_valid = 1'b0;
    logic [DW-1:0]     in_1_data = '0;
    logic              in_1_valid = 1'b0;
    logic              empty_0, empty_1;
    logic [NC-1:0]     cdb_valid = '0;
    logic [NC*TW-1:0]  cdb_tag = '0;
    logic              issue_valid;
    logic [DW-1:0]     issue_data;
    logic              issue_slot;
    logic              issue_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    rs_pair dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_0_data(in_0_data), .in_0_valid(in_0_valid),
        .in_1_data(in_1_data), .in_1_valid(in_1_valid),
        .empty_0(empty_0), .empty_1(empty_1),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .issue_valid(issue_valid), .issue_data(issue_data),
        .issue_slot(issue_slot), .issue_ready(issue_ready)
    );

    always #5 clk = ~clk;

    // Model: each live entry carries an allocation stamp; lower is older.
    logic [DW-1:0] md [2];
    bit            mv [2];
    longint        ms [2];
    bit            mlock;
    bit            mlslot;
    longint        seq;

    function automatic bit m_rdy(input int k);
        return mv[k] && md[k][70] && md[k][64];
    endfunction

    function automatic bit m_ivalid();
        return mlock || m_rdy(0) || m_rdy(1);
    endfunction

    function automatic bit m_slot();
        if (mlock) return mlslot;
        if (m_rdy(0) && m_rdy(1)) return ms[1] < ms[0];
        return m_rdy(1);
    endfunction

    function automatic logic [DW-1:0] m_idata();
        return m_ivalid() ? md[m_slot()] : '0;
    endfunction

    function automatic bit woke(input logic [TW-1:0] t);
        for (int p = 0; p < NC; p++)
            if (cdb_valid[p] && cdb_tag[p*TW +: TW] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] mk(input logic [4:0] t1, input logic r1,
                                         input logic [4:0] t2, input logic r2);
        logic [63:0] lo;
        lo = {$urandom(), $urandom()};
        return {t1, r1, t2, r2, lo};
    endfunction

    task automatic model_reset();
        mv[0] = 0; mv[1] = 0;
        md[0] = '0; md[1] = '0;
        ms[0] = 0; ms[1] = 0;
        mlock = 0; mlslot = 0; seq = 0;
    endtask

    task automatic model_update();
        bit ev, es, acc;
        bit ov [2];
        logic [DW-1:0] nd;
        ev  = m_ivalid();
        es  = m_slot();
        acc = ev && issue_ready;
        if (flush) begin
            mv[0] = 0; mv[1] = 0; mlock = 0;
            return;
        end
        ov = mv;
        for (int k = 0; k < 2; k++) begin
            if (mv[k]) begin
                if (woke(md[k][75:71])) md[k][70] = 1'b1;
                if (woke(md[k][69:65])) md[k][64] = 1'b1;
            end
        end
        if (acc) mv[es] = 0;
        if (acc) mlock = 0;
        else if (ev) begin mlock = 1; mlslot = es; end
        if (in_0_valid && !ov[0]) begin
            nd = in_0_data;
            if (woke(nd[75:71])) nd[70] = 1'b1;
            if (woke(nd[69:65])) nd[64] = 1'b1;
            md[0] = nd; mv[0] = 1; ms[0] = seq; seq++;
        end
        if (in_1_valid && !ov[1]) begin
            nd = in_1_data;
            if (woke(nd[75:71])) nd[70] = 1'b1;
            if (woke(nd[69:65])) nd[64] = 1'b1;
            md[1] = nd; mv[1] = 1; ms[1] = seq; seq++;
        end
    endtask

    task automatic idle();
        flush = 0; in_0_valid = 0; in_1_valid = 0;
        cdb_valid = '0; cdb_tag = '0; issue_ready = 0;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (empty_0 !== 1'b1 || empty_1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_empty got %b%b want 11", empty_0, empty_1);
        end
        vectors++;
        if (issue_valid !== 1'b0 || issue_slot !== 1'b0 || issue_data !== '0) begin
            miscompares++;
            $display("FAIL reset_issue got v=%b s=%b d=%h want 0/0/0",
                     issue_valid, issue_slot, issue_data);
        end
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_issue_basic();
        logic [DW-1:0] d;
        d = mk(5'd3, 1, 5'd4, 1);
        in_0_data = d; in_0_valid = 1;
        tick();
        idle();
        vectors++;
        if (empty_0 !== 1'b0 || issue_valid !== 1'b1 || issue_slot !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_offer got e0=%b v=%b s=%b want 0/1/0",
                     empty_0, issue_valid, issue_slot);
        end
        vectors++;
        if (issue_data !== d) begin
            miscompares++;
            $display("FAIL basic_data got %h want %h", issue_data, d);
        end
        issue_ready = 1;
        tick();
        idle();
        vectors++;
        if (empty_0 !== 1'b1 || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_free got e0=%b v=%b want 1/0", empty_0, issue_valid);
        end
    endtask

    task automatic test_wakeup();
        in_0_data = mk(5'd5, 0, 5'd9, 1); in_0_valid = 1;
        tick();
        idle();
        vectors++;
        if (issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wake_wait got v=%b want 0", issue_valid);
        end
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd5};
        tick();
        idle();
        vectors++;
        if (issue_valid !== 1'b1 || issue_data[70] !== 1'b1 || issue_data !== m_idata()) begin
            miscompares++;
            $display("FAIL wake_issue got v=%b d=%h want 1/%h",
                     issue_valid, issue_data, m_idata());
        end
        issue_ready = 1;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        in_0_data = mk(5'd7, 0, 5'd2, 1); in_0_valid = 1;
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd7};
        tick();
        idle();
        vectors++;
        if (issue_valid !== 1'b1 || issue_data[70] !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass got v=%b rdy1=%b want 1/1", issue_valid, issue_data[70]);
        end
        issue_ready = 1;
        tick();
        idle();
    endtask

    task automatic test_age();
        logic [DW-1:0] d0, d1;
        d1 = mk(5'd1, 1, 5'd1, 1);
        d0 = mk(5'd2, 1, 5'd2, 1);
        in_1_data = d1; in_1_valid = 1;
        tick();
        idle();
        in_0_data = d0; in_0_valid = 1;
        tick();
        idle();
        issue_ready = 1;
        vectors++;
        if (issue_slot !== 1'b1 || issue_data !== d1) begin
            miscompares++;
            $display("FAIL age_first got s=%b d=%h want 1/%h", issue_slot, issue_data, d1);
        end
        tick();
        vectors++;
        if (issue_valid !== 1'b1 || issue_slot !== 1'b0 || issue_data !== d0) begin
            miscompares++;
            $display("FAIL age_second got v=%b s=%b d=%h want 1/0/%h",
                     issue_valid, issue_slot, issue_data, d0);
        end
        tick();
        idle();
        vectors++;
        if (empty_0 !== 1'b1 || empty_1 !== 1'b1) begin
            miscompares++;
            $display("FAIL age_drain got %b%b want 11", empty_0, empty_1);
        end
    endtask

    task automatic test_stall();
        in_1_data = mk(5'd11, 0, 5'd3, 1); in_1_valid = 1;
        tick();
        idle();
        in_0_data = mk(5'd4, 1, 5'd6, 1); in_0_valid = 1;
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                cdb_valid = 2'b10; cdb_tag = {5'd11, 5'd0};
            end
            vectors++;
            if (issue_valid !== 1'b1 || issue_slot !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold c=%0d got v=%b s=%b want 1/0",
                         c, issue_valid, issue_slot);
            end
            tick();
            idle();
        end
        issue_ready = 1;
        vectors++;
        if (issue_slot !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_accept got s=%b want 0", issue_slot);
        end
        tick();
        vectors++;
        if (issue_valid !== 1'b1 || issue_slot !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_next got v=%b s=%b want 1/1", issue_valid, issue_slot);
        end
        tick();
        idle();
    endtask

    task automatic test_flush();
        in_0_data = mk(5'd20, 0, 5'd21, 0); in_0_valid = 1;
        in_1_data = mk(5'd22, 1, 5'd23, 1); in_1_valid = 1;
        tick();
        idle();
        vectors++;
        if (empty_0 !== 1'b0 || empty_1 !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_fill got %b%b want 00", empty_0, empty_1);
        end
        in_0_data = mk(5'd1, 1, 5'd1, 1); in_0_valid = 1;
        flush = 1; issue_ready = 1;
        tick();
        idle();
        vectors++;
        if (empty_0 !== 1'b1 || empty_1 !== 1'b1 || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear got e=%b%b v=%b want 11/0",
                     empty_0, empty_1, issue_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            flush       = ($urandom_range(0, 24) == 0);
            in_0_valid  = !mv[0] && $urandom_range(0, 1);
            in_1_valid  = !mv[1] && $urandom_range(0, 1);
            in_0_data   = mk(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            in_1_data   = mk(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            cdb_valid   = 2'($urandom_range(0, 3));
            cdb_tag     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            issue_ready = ($urandom_range(0, 2) != 0);
            vectors++;
            if (empty_0 !== !mv[0] || empty_1 !== !mv[1]) begin
                miscompares++;
                $display("FAIL rand_empty i=%0d got %b%b want %b%b",
                         i, empty_0, empty_1, !mv[0], !mv[1]);
            end
            vectors++;
            if (issue_valid !== m_ivalid()) begin
                miscompares++;
                $display("FAIL rand_valid i=%0d got %b want %b", i, issue_valid, m_ivalid());
            end
            if (m_ivalid()) begin
                vectors++;
                if (issue_slot !== m_slot() || issue_data !== m_idata()) begin
                    miscompares++;
                    $display("FAIL rand_issue i=%0d got s=%b d=%h want s=%b d=%h",
                             i, issue_slot, issue_data, m_slot(), m_idata());
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_issue_basic();
        test_wakeup();
        test_bypass();
        test_age();
        test_stall();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
